// File: rtl/idli_fetch_if.sv
// idli_fetch_if: bundles the fetch unit's control, SQI pad and decoder-side signals.
//   master (fetch unit) drives:  o_sqi_cs_n, o_sqi_sio_oe, o_sqi_sio_out, o_dcd_enc,
//                                o_dcd_enc_vld, o_fetch_pc
//   master (fetch unit) samples: i_fetch_stall, i_fetch_redirect, i_fetch_redirect_pc,
//                                i_sqi_sio_in
//   slave is the mirror image (pads, backend and decoder side).
interface idli_fetch_if;
   logic        i_fetch_stall;
   logic        i_fetch_redirect;
   logic [15:0] i_fetch_redirect_pc;
   logic        o_sqi_cs_n;
   logic        o_sqi_sio_oe;
   logic [3:0]  o_sqi_sio_out;
   logic [3:0]  i_sqi_sio_in;
   logic [3:0]  o_dcd_enc;
   logic        o_dcd_enc_vld;
   logic [15:0] o_fetch_pc;
   modport master (
      input  i_fetch_stall, i_fetch_redirect, i_fetch_redirect_pc, i_sqi_sio_in,
      output o_sqi_cs_n, o_sqi_sio_oe, o_sqi_sio_out, o_dcd_enc, o_dcd_enc_vld, o_fetch_pc
   );
   modport slave (
      output i_fetch_stall, i_fetch_redirect, i_fetch_redirect_pc, i_sqi_sio_in,
      input  o_sqi_cs_n, o_sqi_sio_oe, o_sqi_sio_out, o_dcd_enc, o_dcd_enc_vld, o_fetch_pc
   );
endinterface

// File: rtl/idli_fetch_m.sv
// idli_fetch_m: SQI instruction fetch; sends READ command, address and dummy cycles, then
// streams 16b instructions to the decoder as four MSB-first nibbles.
//   i_dcd_gck    clock
//   i_dcd_rst_n  asynchronous active-low reset
//   fetch        idli_fetch_if.master: stall/redirect in, SQI pads, decoder nibble + pc out
module idli_fetch_m #(
   parameter logic [15:0] RESET_PC     = 16'h0000,
   parameter logic [7:0]  READ_CMD     = 8'h03,
   parameter int unsigned DUMMY_CYCLES = 2
) (
   input logic          i_dcd_gck,
   input logic          i_dcd_rst_n,
   idli_fetch_if.master fetch
);
   typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA} state_t;
   localparam logic [2:0]  DUMMY_LAST = 3'(DUMMY_CYCLES - 1);
   localparam logic [15:0] RESET_PC_A = {RESET_PC[15:1], 1'b0};
   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] tgt_q, tgt_d;
   logic        pend_q, pend_d;
   always_ff @(posedge i_dcd_gck or negedge i_dcd_rst_n) begin
      if (!i_dcd_rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 3'd0;
         pc_q    <= RESET_PC_A;
         tgt_q   <= 16'h0000;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
         pend_q  <= pend_d;
      end
   end
   // A pending redirect outside DATA aborts the burst at once; inside DATA it waits for the
   // instruction boundary so the decoder never sees a truncated instruction.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 3'd1;
      pc_d    = pc_q;
      pend_d  = pend_q;
      tgt_d   = tgt_q;
      if (pend_q && state_q != ST_DATA) begin
         pc_d    = tgt_q;
         pend_d  = 1'b0;
         state_d = ST_IDLE;
         cnt_d   = 3'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               cnt_d   = 3'd0;
               state_d = fetch.i_fetch_stall ? ST_IDLE : ST_CMD;
            end
            ST_CMD:
               if (cnt_q == 3'd1) begin
                  state_d = ST_ADDR;
                  cnt_d   = 3'd0;
               end
            ST_ADDR:
               if (cnt_q == 3'd3) begin
                  state_d = ST_DUMMY;
                  cnt_d   = 3'd0;
               end
            ST_DUMMY:
               if (cnt_q == DUMMY_LAST) begin
                  state_d = ST_DATA;
                  cnt_d   = 3'd0;
               end
            ST_DATA:
               if (cnt_q == 3'd3) begin
                  cnt_d = 3'd0;
                  pc_d  = pc_q + 16'd2;
                  if (pend_q) begin
                     pc_d    = tgt_q;
                     pend_d  = 1'b0;
                     state_d = ST_IDLE;
                  end else if (fetch.i_fetch_stall) begin
                     state_d = ST_IDLE;
                  end
               end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = 3'd0;
            end
         endcase
      end
      // Latest redirect wins, including one arriving while an older one is being consumed.
      if (fetch.i_fetch_redirect) begin
         pend_d = 1'b1;
         tgt_d  = {fetch.i_fetch_redirect_pc[15:1], 1'b0};
      end
   end
   logic [3:0] addr_nib;
   // pc_q is always even, so its low nibble already carries the forced-zero bit 0.
   assign addr_nib = cnt_q[1:0] == 2'd0 ? pc_q[15:12] :
                     cnt_q[1:0] == 2'd1 ? pc_q[11:8]  :
                     cnt_q[1:0] == 2'd2 ? pc_q[7:4]   : pc_q[3:0];
   assign fetch.o_sqi_cs_n    = state_q == ST_IDLE;
   assign fetch.o_sqi_sio_oe  = state_q == ST_CMD || state_q == ST_ADDR;
   assign fetch.o_sqi_sio_out = state_q == ST_CMD  ? (cnt_q == 3'd0 ? READ_CMD[7:4] : READ_CMD[3:0]) :
                                state_q == ST_ADDR ? addr_nib : 4'h0;
   assign fetch.o_dcd_enc     = fetch.i_sqi_sio_in;
   assign fetch.o_dcd_enc_vld = state_q == ST_DATA;
   assign fetch.o_fetch_pc    = pc_q;
endmodule
